input_debouncer: RTL and testbench
==================================

// Module: input_debouncer
// PURPOSE
//  Synchronises and debounces WIDTH raw board inputs (switches/buttons) before they drive the
//  basic logic gates (e.g. the 1-bit AND gate's a/b inputs). Each channel passes through a
//  SYNC_STAGES flop synchroniser and then a per-channel stability FSM with a counter.
//  Outputs are clean, glitch-free levels in the clk domain.
// PARAMETERS
//  WIDTH        2          number of independent input channels
//  CNT_MAX      1_000_000  consecutive stable cycles required to accept a new level (>=2)
//  SYNC_STAGES  2          synchroniser depth (>=2)
// PORTS
//  clk     in   1      system clock; all state on rising edge
//  rst     in   1      asynchronous, active-high reset
//  raw     in   WIDTH  asynchronous board inputs
//  clean   out  WIDTH  debounced level per channel
//  rise    out  WIDTH  1-cycle pulse when clean[i] goes 0->1 (see CONFIGURATION)
//  fall    out  WIDTH  1-cycle pulse when clean[i] goes 1->0 (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async assert, sync release): sync flops=0, state=STABLE_LO, cnt=0, clean=0,
//    rise=0, fall=0. Reset mid-count discards progress; raw already high after release needs
//    a full debounce before clean rises.
//  - s[i] = last synchroniser stage. Channels fully independent; simultaneous events on several
//    channels are handled in the same cycle with no interaction.
//  - FSM per channel: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
//    STABLE_LO: s=1 -> WAIT_HI, cnt=0. STABLE_HI: s=0 -> WAIT_LO, cnt=0.
//    WAIT_HI: s=0 -> STABLE_LO, cnt=0 (glitch rejected); else cnt==CNT_MAX-1 -> STABLE_HI,
//      clean=1, cnt=0; else cnt++. WAIT_LO mirrors with levels inverted.
//  - clean is registered and changes only on WAIT_x -> STABLE_x transitions.
//  - Latency: raw sampled high at edge E -> clean=1 after edge E+SYNC_STAGES+CNT_MAX.
//    Pulse shorter than CNT_MAX cycles at s never reaches clean.
//  - cnt width = $clog2(CNT_MAX); counter never wraps (cleared before reaching CNT_MAX).
//  - Bouncing input: every return to old level restarts the count; one clean transition only.
// CONFIGURATION
//  - Macro DEBOUNCE_EDGE_PULSE_EN.
//  - Defined: rise[i]/fall[i] are registered, high for exactly one cycle coincident with the
//    first cycle clean[i] shows its new value.
//  - Undefined: edge logic not built; rise and fall ports remain and are tied to 0.
// STRUCTURE
//  - Shared package debounce_pkg: 2-bit state encoding (STABLE_LO=0, WAIT_HI=1, STABLE_HI=2,
//    WAIT_LO=3) and DEFAULT_CNT_MAX.
//  - Sub-module debounce_channel (1 bit: synchroniser + FSM + counter + optional edge regs),
//    instantiated WIDTH times in a generate loop; top is wiring only.
// TESTING (bench uses CNT_MAX=4, SYNC_STAGES=2; latency = 6 edges)
//  1. rst=1 with raw=2'b11 -> clean=00, rise=fall=00 throughout; release -> clean=11 at 6th
//     edge after first sampling edge post-release.
//  2. raw[0] 0->1 held -> clean[0]=1 exactly 6 edges later; rise[0] high that one cycle only;
//     clean[1] unchanged.
//  3. raw[1] high for 3 cycles then low -> clean[1] stays 0, no rise/fall pulses.
//  4. raw[0] toggles every 2 cycles for 12 cycles then held 1 -> one rise[0] pulse, clean[0]=1
//     6 edges after final low->high change.
//  5. rst pulsed while channel 0 in WAIT_HI with cnt=2 -> clean=0 immediately, cnt=0; full
//     6-edge latency required again after release.
//  6. raw 00->11 same edge -> both clean bits and both rise bits assert same cycle; rebuild
//     without DEBOUNCE_EDGE_PULSE_EN -> rise=fall=00 always, clean timing identical.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the input debouncer: per-channel FSM state encoding
// and the default stability count.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_e;

    localparam int DEFAULT_CNT_MAX = 1_000_000;

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, stability FSM with counter, and edge pulses
// that are built only when DEBOUNCE_EDGE_PULSE_EN is defined (tied to 0 otherwise).
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int CNT_MAX     = DEFAULT_CNT_MAX,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int            CW       = $clog2(CNT_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   clean_q, clean_d;

    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    // NOTE: defaults first, so no path through the case can leave a variable unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        case (state_q)
            STABLE_LO: if (s) begin
                state_d = WAIT_HI;
                cnt_d   = '0;
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    clean_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE_HI: if (!s) begin
                state_d = WAIT_LO;
                cnt_d   = '0;
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    clean_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    assign clean_o = clean_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic rise_q, fall_q;

    // Pulses are registered from the same next-state as clean, so they line up with its change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= clean_d & ~clean_q;
            fall_q <= ~clean_d & clean_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/input_debouncer.sv
// WIDTH independent debounced inputs; wiring only around debounce_channel.
// Edge pulses on rise/fall exist only when DEBOUNCE_EDGE_PULSE_EN is defined.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int CNT_MAX     = DEFAULT_CNT_MAX,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .CNT_MAX     (CNT_MAX),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (raw[i]),
            .clean_o (clean[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with CNT_MAX=4, SYNC_STAGES=2 (7th sampling edge
// after a raw change shows the new clean level); edge expectations follow DEBOUNCE_EDGE_PULSE_EN.
module tb_input_debouncer;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] raw;
    logic [1:0] clean, rise, fall;

    int n_checks = 0;
    int n_fail   = 0;

    input_debouncer #(
        .WIDTH       (2),
        .CNT_MAX     (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .raw   (raw),
        .clean (clean),
        .rise  (rise),
        .fall  (fall)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] c, input logic [1:0] r,
                              input logic [1:0] f);
        check({tag, ".clean"}, clean, c);
        check({tag, ".rise"}, rise, EDGE_EN ? r : 2'b00);
        check({tag, ".fall"}, fall, EDGE_EN ? f : 2'b00);
    endtask

    task automatic hold(input string tag, input int n, input logic [1:0] c);
        for (int i = 0; i < n; i++) begin
            step();
            check_outs(tag, c, 2'b00, 2'b00);
        end
    endtask

    // Apply a raw level and follow it through: old level for 6 edges, new level with a
    // one-cycle pulse on the 7th, pulse gone on the 8th.
    task automatic settle(input string tag, input logic [1:0] new_raw,
                          input logic [1:0] old_c, input logic [1:0] new_c);
        raw = new_raw;
        hold({tag, ".wait"}, 6, old_c);
        step();
        check_outs({tag, ".edge"}, new_c, new_c & ~old_c, old_c & ~new_c);
        step();
        check_outs({tag, ".after"}, new_c, 2'b00, 2'b00);
    endtask

    initial begin
        rst = 1'b1;
        raw = 2'b11;

        // 1: raw high throughout reset, full latency after release
        #1;
        check_outs("t1.rst_async", 2'b00, 2'b00, 2'b00);
        hold("t1.rst_held", 3, 2'b00);
        rst = 1'b0;
        settle("t1.release", 2'b11, 2'b00, 2'b11);
        settle("t1.back_lo", 2'b00, 2'b11, 2'b00);

        // 2: channel 0 alone rises, channel 1 untouched
        settle("t2.ch0_rise", 2'b01, 2'b00, 2'b01);

        // 3: 3-cycle pulse on channel 1 is rejected
        raw = 2'b11;
        hold("t3.pulse", 3, 2'b01);
        raw = 2'b01;
        hold("t3.after", 10, 2'b01);

        // 4: bouncing channel 0 gives one clean rise after the last low->high
        settle("t4.prep_lo", 2'b00, 2'b01, 2'b00);
        for (int k = 0; k < 6; k++) begin
            raw = 2'b01;
            hold("t4.bounce_hi", 2, 2'b00);
            raw = 2'b00;
            hold("t4.bounce_lo", 2, 2'b00);
        end
        settle("t4.final", 2'b01, 2'b00, 2'b01);

        // 5: reset while channel 0 is in WAIT_HI with cnt=2 discards the count
        settle("t5.prep_lo", 2'b00, 2'b01, 2'b00);
        raw = 2'b01;
        hold("t5.counting", 5, 2'b00);
        #2;
        rst = 1'b1;
        #1;
        check_outs("t5.rst_async", 2'b00, 2'b00, 2'b00);
        hold("t5.rst_held", 2, 2'b00);
        rst = 1'b0;
        settle("t5.release", 2'b01, 2'b00, 2'b01);

        // 6: both channels change on the same edge
        settle("t6.prep_lo", 2'b00, 2'b01, 2'b00);
        settle("t6.both_rise", 2'b11, 2'b00, 2'b11);
        settle("t6.both_fall", 2'b00, 2'b11, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
